input_conditioner: RTL and testbench
====================================

# input_conditioner

Upstream input stage for the chip's dedicated 8-bit input pins. Each raw pad bit passes through a synchroniser and a per-bit debounce counter, which together produce a clean, stable word for the downstream core logic. The block also provides per-bit rise/fall strobes and a single-entry change-event register with a valid/ack handshake and a sticky overflow flag. It sits between the pad inputs and the core's input port.

## Interface
Parameters:
- `WIDTH`, 8, number of input bits.
- `SYNC_STAGES`, 2, flops in each synchroniser chain. Must be at least 2.
- `DEBOUNCE_CYCLES`, 16, consecutive differing samples required before an output bit flips. Must be at least 2. The counter width is `$clog2(DEBOUNCE_CYCLES)`.

Ports:
- `clk` in 1: the single clock; all state is on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `din` in WIDTH: raw, asynchronous pad inputs.
- `dout` out WIDTH: debounced, registered input word.
- `rise` out WIDTH: one-cycle strobe per bit when `dout[i]` goes 0→1.
- `fall` out WIDTH: one-cycle strobe per bit when `dout[i]` goes 1→0.
- `evt_valid` out 1: a change event is pending.
- `evt_data` out WIDTH: value of `dout` captured at the most recent change.
- `evt_ack` in 1: consumer acknowledge. It is only meaningful while `evt_valid` is 1.
- `ovf` out 1: sticky flag; an event was overwritten before it was acknowledged.
- `ovf_clr` in 1: synchronous clear for `ovf`.

## Operation
- **Synchroniser:** each bit of `din` passes through a chain of `SYNC_STAGES` flops. The last stage is `s[i]`.
- **Debounce, per bit, on every edge:**
  - If `s[i] == dout[i]`, then `cnt[i]` is set to 0.
  - Else if `cnt[i] == DEBOUNCE_CYCLES-1`, then `dout[i]` is set to `s[i]` and `cnt[i]` is set to 0.
  - Else `cnt[i]` is set to `cnt[i]+1`.
  - A glitch shorter than `DEBOUNCE_CYCLES` samples therefore never reaches `dout`, and the counter restarts from 0.
- **Edge strobes:** `rise[i]` and `fall[i]` are registered. They assert on the same edge that `dout[i]` updates and deassert on the next edge.
- **Change detection:** `chg` is 1 on an edge where at least one `dout` bit flips. Several bits flipping on the same edge produce one event.
- **Event register, evaluated on each edge:**
  - `chg` with `evt_valid` = 0: set `evt_valid` to 1 and load `evt_data` with the new `dout`.
  - `chg` with `evt_valid` = 1 and `evt_ack` = 1: `evt_valid` stays 1, `evt_data` takes the new `dout`, and there is no overflow.
  - `chg` with `evt_valid` = 1 and `evt_ack` = 0: `evt_data` takes the new `dout` (newest value wins) and `ovf` is set to 1.
  - No `chg`, with `evt_valid` = 1 and `evt_ack` = 1: clear `evt_valid`. `evt_data` holds its value.
  - `evt_ack` while `evt_valid` = 0: ignored.
- **Overflow flag:**
  - `ovf_clr` = 1 clears `ovf` on the next edge.
  - If a new overflow occurs on the same edge as `ovf_clr`, the set wins and `ovf` stays 1.
- **Reset:** while `rst` is 1, the following are all 0: synchroniser flops, `cnt`, `dout`, `rise`, `fall`, `evt_valid`, `evt_data`, `ovf`. A reset asserted mid-count discards any partial count.
- **Power-up with high inputs:** the reset value of `dout` is 0. If `din` is already 1 at reset release, that bit is debounced normally and produces a `rise` strobe and an event.

## Timing
- **Latency:** a `din` bit changes before edge 0 and then stays stable. With `S = SYNC_STAGES` and `D = DEBOUNCE_CYCLES`:
  - `s[i]` changes at edge S.
  - `dout[i]`, `rise`/`fall` and `evt_valid` all update at edge S+D. With the defaults this is edge 18.
- **Strobe width:** `rise` and `fall` are exactly one cycle wide.
- **Event visibility:** `evt_valid` is visible in the same cycle as the `dout` change.
- **Earliest acknowledge:** the consumer may acknowledge in that same cycle. `evt_valid` then drops on the following edge.
- **Reset release:** after `rst` deasserts, the first synchroniser capture happens on the first rising edge.
- **Outputs:** every output is driven directly from a flop. There are no combinational paths from inputs to outputs.

## Test plan
1. **Clean rise:** reset, then set `din`=0x01 and hold. Required: `dout`=0x01, `rise`=0x01 for one cycle, and `evt_valid`=1 with `evt_data`=0x01, all exactly at edge 18. `evt_ack` pulsed for one cycle then clears `evt_valid`.
2. **Glitch rejection:** pulse `din[3]` high for 15 cycles, then return it low. Required: `dout` stays 0x00, with no strobes and no event.
3. **Bounce then settle:** toggle `din[0]` every 5 cycles 6 times, then hold it at 1. Required: exactly one `rise[0]`, 18 edges after the final transition into 1.
4. **Overflow:** change `din` to 0x0F, wait for `evt_valid`, do not acknowledge, then change `din` to 0xF0. Required: `evt_data`=0xF0, `ovf`=1. Then `ovf_clr` is pulsed with no new change, and `ovf` must return to 0.
5. **Acknowledge collides with change:** hold `evt_ack`=1 on the exact edge a new change lands. Required: `evt_valid` stays 1, `evt_data` holds the new value, and `ovf` stays 0.
6. **Reset mid-count:** hold `din`=0xFF for 10 cycles, assert `rst` asynchronously between edges, then release it. Required: all outputs 0 immediately on assertion. After release, `dout`=0xFF at edge 18 post-release, and `rise`=0xFF for one cycle.

Source files
------------

// File: rtl/input_conditioner.sv
// ---------------------------------------------------------------------------
// input_conditioner
//
// Cleans up the chip's raw pad inputs before the core sees them. Each bit is
// synchronised into the clock domain, then debounced by a per-bit counter so
// that only a level held for DEBOUNCE_CYCLES consecutive samples reaches
// dout. Alongside the clean word the block emits per-bit rise/fall strobes
// and holds the most recent changed word in a single-entry event register
// with a valid/ack handshake and a sticky overflow flag.
//
// Ports
//   clk        in   single clock, rising edge
//   rst        in   asynchronous active-high reset
//   din        in   raw asynchronous pad inputs [WIDTH]
//   dout       out  debounced input word [WIDTH]
//   rise       out  one-cycle strobe per bit on a dout 0->1 flip [WIDTH]
//   fall       out  one-cycle strobe per bit on a dout 1->0 flip [WIDTH]
//   evt_valid  out  a change event is pending
//   evt_data   out  dout value captured at the most recent change [WIDTH]
//   evt_ack    in   consumer acknowledge, only meaningful while evt_valid
//   ovf        out  sticky: an event was overwritten before being acked
//   ovf_clr    in   synchronous clear for ovf
//
// Every output comes straight from a flop; nothing is combinational from an
// input to an output.
// ---------------------------------------------------------------------------
module input_conditioner #(
   parameter int WIDTH           = 8,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall,
   output logic             evt_valid,
   output logic [WIDTH-1:0] evt_data,
   input  logic             evt_ack,
   output logic             ovf,
   input  logic             ovf_clr
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   // Synchroniser chain: stage 0 samples the pads, the last stage is the
   // settled sample the debouncer works from.
   logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
   logic [WIDTH-1:0]                  s;

   // Debounce state and the next-state values computed for this edge.
   logic [WIDTH-1:0][CNT_W-1:0] cnt;
   logic [WIDTH-1:0][CNT_W-1:0] cnt_next;
   logic [WIDTH-1:0]            dout_next;

   logic chg;
   logic ovf_set;

   assign s = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      end
   end

   // Per-bit debounce. Any sample that agrees with dout restarts the count,
   // so a glitch shorter than DEBOUNCE_CYCLES samples never gets through.
   // The flip happens on the sample that finds the counter already at its
   // maximum, i.e. the DEBOUNCE_CYCLES-th consecutive differing sample.
   always_comb begin
      cnt_next  = cnt;
      dout_next = dout;
      for (int i = 0; i < WIDTH; i++) begin
         if (s[i] == dout[i]) begin
            cnt_next[i] = '0;
         end else if (cnt[i] == CNT_MAX) begin
            dout_next[i] = s[i];
            cnt_next[i]  = '0;
         end else begin
            cnt_next[i] = cnt[i] + CNT_ONE;
         end
      end
   end

   // Several bits flipping together still form a single event.
   assign chg     = |(dout_next ^ dout);
   assign ovf_set = chg & evt_valid & ~evt_ack;

   // Debounced word and its strobes. The strobes are derived from the same
   // next-state as dout so they land on exactly the edge dout updates.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt  <= '0;
         dout <= '0;
         rise <= '0;
         fall <= '0;
      end else begin
         cnt  <= cnt_next;
         dout <= dout_next;
         rise <= dout_next & ~dout;
         fall <= ~dout_next & dout;
      end
   end

   // Single-entry event register. A new change always wins and loads the
   // newest word; an ack on the same edge as a change keeps the entry valid
   // because the fresh change has not been seen yet. Without a change, an
   // ack retires the entry and evt_data keeps its last value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         evt_valid <= 1'b0;
         evt_data  <= '0;
      end else if (chg) begin
         evt_valid <= 1'b1;
         evt_data  <= dout_next;
      end else if (evt_valid && evt_ack) begin
         evt_valid <= 1'b0;
      end
   end

   // Sticky overflow. A fresh overflow takes priority over a clear request
   // arriving on the same edge so that no overwrite goes unreported.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf <= 1'b0;
      end else if (ovf_set) begin
         ovf <= 1'b1;
      end else if (ovf_clr) begin
         ovf <= 1'b0;
      end
   end

endmodule

// File: tb/tb_input_conditioner.sv
// ---------------------------------------------------------------------------
// tb_input_conditioner
//
// Directed bench for input_conditioner. Whenever a pad change is issued that
// should eventually flip dout, the expected strobe/event snapshot (including
// the absolute cycle it must appear on) is pushed into a queue. An
// independent monitor watches for rise/fall strobes on the falling edge and
// pops one expectation per strobe cycle; a strobe with nothing queued is an
// error, as is anything left queued at the end. Static state (reset values,
// ack and clear behaviour) is checked directly by the stimulus process.
// ---------------------------------------------------------------------------
module tb_input_conditioner;

   localparam int WIDTH           = 8;
   localparam int SYNC_STAGES     = 2;
   localparam int DEBOUNCE_CYCLES = 16;
   localparam int LAT             = SYNC_STAGES + DEBOUNCE_CYCLES;

   typedef struct {
      int               cyc;
      logic [WIDTH-1:0] dout;
      logic [WIDTH-1:0] rise;
      logic [WIDTH-1:0] fall;
      logic [WIDTH-1:0] data;
      logic             ovf;
   } exp_t;

   logic             clk;
   logic             rst;
   logic [WIDTH-1:0] din;
   logic [WIDTH-1:0] dout;
   logic [WIDTH-1:0] rise;
   logic [WIDTH-1:0] fall;
   logic             evt_valid;
   logic [WIDTH-1:0] evt_data;
   logic             evt_ack;
   logic             ovf;
   logic             ovf_clr;

   exp_t sb[$];
   int   cyc      = 0;
   int   n_checks = 0;
   int   n_pass   = 0;

   input_conditioner #(
      .WIDTH          (WIDTH),
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .din      (din),
      .dout     (dout),
      .rise     (rise),
      .fall     (fall),
      .evt_valid(evt_valid),
      .evt_data (evt_data),
      .evt_ack  (evt_ack),
      .ovf      (ovf),
      .ovf_clr  (ovf_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Absolute edge counter used to time-stamp expectations.
   always @(posedge clk) cyc = cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      n_checks++;
      if (actual === expected) begin
         n_pass++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                  name, actual, expected, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic waitCycles(input int n);
      repeat (n) tick();
   endtask

   task automatic applyStimulus(input logic [WIDTH-1:0] value);
      din = value;
   endtask

   // Queue the snapshot the monitor must see LAT edges from now.
   task automatic expectEvent(input logic [WIDTH-1:0] e_dout,
                              input logic [WIDTH-1:0] e_rise,
                              input logic [WIDTH-1:0] e_fall,
                              input logic [WIDTH-1:0] e_data,
                              input logic             e_ovf);
      exp_t e;
      e.cyc  = cyc + LAT;
      e.dout = e_dout;
      e.rise = e_rise;
      e.fall = e_fall;
      e.data = e_data;
      e.ovf  = e_ovf;
      sb.push_back(e);
   endtask

   task automatic ackEvent(input string name);
      evt_ack = 1'b1;
      tick();
      evt_ack = 1'b0;
      checkOutput(name, {31'd0, evt_valid}, 32'd0);
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_dout"},  {24'd0, dout},      32'd0);
      checkOutput({tag, "_rise"},  {24'd0, rise},      32'd0);
      checkOutput({tag, "_fall"},  {24'd0, fall},      32'd0);
      checkOutput({tag, "_valid"}, {31'd0, evt_valid}, 32'd0);
      checkOutput({tag, "_data"},  {24'd0, evt_data},  32'd0);
      checkOutput({tag, "_ovf"},   {31'd0, ovf},       32'd0);
   endtask

   // Monitor: every cycle that carries a strobe must match the next queued
   // expectation, including the cycle it was predicted for.
   always @(negedge clk) begin
      exp_t e;
      if ((rise | fall) != '0) begin
         if (sb.size() == 0) begin
            n_checks++;
            $display("[TB] FAIL unexpected_strobe: got rise=0x%0h fall=0x%0h, expected none (cycle %0d)",
                     rise, fall, cyc);
         end else begin
            e = sb.pop_front();
            checkOutput("evt_cycle", cyc,                e.cyc);
            checkOutput("evt_dout",  {24'd0, dout},      {24'd0, e.dout});
            checkOutput("evt_rise",  {24'd0, rise},      {24'd0, e.rise});
            checkOutput("evt_fall",  {24'd0, fall},      {24'd0, e.fall});
            checkOutput("evt_valid", {31'd0, evt_valid}, 32'd1);
            checkOutput("evt_data",  {24'd0, evt_data},  {24'd0, e.data});
            checkOutput("evt_ovf",   {31'd0, ovf},       {31'd0, e.ovf});
         end
      end
   end

   initial begin
      rst     = 1'b1;
      din     = '0;
      evt_ack = 1'b0;
      ovf_clr = 1'b0;

      waitCycles(3);
      checkAllZero("reset");
      rst = 1'b0;
      waitCycles(2);

      // Clean rise on bit 0, acknowledged in the same cycle it appears.
      $display("[TB] clean rise");
      applyStimulus(8'h01);
      expectEvent(8'h01, 8'h01, 8'h00, 8'h01, 1'b0);
      waitCycles(LAT);
      ackEvent("rise_ack_clears_valid");
      checkOutput("rise_ack_data_holds", {24'd0, evt_data}, 32'h01);

      // A 15-cycle pulse on bit 3 is one sample short and must vanish.
      $display("[TB] glitch rejection");
      applyStimulus(8'h09);
      waitCycles(15);
      applyStimulus(8'h01);
      waitCycles(25);
      checkOutput("glitch_dout",  {24'd0, dout},      32'h01);
      checkOutput("glitch_valid", {31'd0, evt_valid}, 32'd0);

      // Return bit 0 low, then bounce it before it settles high.
      $display("[TB] bounce then settle");
      applyStimulus(8'h00);
      expectEvent(8'h00, 8'h00, 8'h01, 8'h00, 1'b0);
      waitCycles(LAT);
      ackEvent("fall_ack_clears_valid");
      for (int k = 0; k < 6; k++) begin
         applyStimulus((k % 2 == 0) ? 8'h01 : 8'h00);
         waitCycles(5);
      end
      applyStimulus(8'h01);
      expectEvent(8'h01, 8'h01, 8'h00, 8'h01, 1'b0);
      waitCycles(LAT);
      ackEvent("bounce_ack_clears_valid");

      // Second change overwrites an unacknowledged event.
      $display("[TB] overflow");
      applyStimulus(8'h0F);
      expectEvent(8'h0F, 8'h0E, 8'h00, 8'h0F, 1'b0);
      waitCycles(LAT);
      applyStimulus(8'hF0);
      expectEvent(8'hF0, 8'hF0, 8'h0F, 8'hF0, 1'b1);
      waitCycles(LAT);
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      checkOutput("ovf_cleared",       {31'd0, ovf},       32'd0);
      checkOutput("ovf_valid_pending", {31'd0, evt_valid}, 32'd1);
      checkOutput("ovf_data_newest",   {24'd0, evt_data},  32'hF0);
      ackEvent("ovf_ack_clears_valid");

      // Ack held on the exact edge a second change lands.
      $display("[TB] ack collides with change");
      applyStimulus(8'h00);
      expectEvent(8'h00, 8'h00, 8'hF0, 8'h00, 1'b0);
      waitCycles(5);
      applyStimulus(8'h03);
      expectEvent(8'h03, 8'h03, 8'h00, 8'h03, 1'b0);
      waitCycles(LAT - 1);
      evt_ack = 1'b1;
      tick();
      evt_ack = 1'b0;
      checkOutput("collide_valid", {31'd0, evt_valid}, 32'd1);
      checkOutput("collide_data",  {24'd0, evt_data},  32'h03);
      checkOutput("collide_ovf",   {31'd0, ovf},       32'd0);
      ackEvent("collide_ack_clears_valid");

      // Asynchronous reset in the middle of a debounce count.
      $display("[TB] reset mid-count");
      applyStimulus(8'hFF);
      waitCycles(10);
      #2;
      rst = 1'b1;
      #1;
      checkAllZero("async_reset");
      waitCycles(3);
      rst = 1'b0;
      expectEvent(8'hFF, 8'hFF, 8'h00, 8'hFF, 1'b0);
      waitCycles(LAT);
      ackEvent("post_reset_ack_clears_valid");
      waitCycles(5);

      if (sb.size() != 0) begin
         n_checks++;
         $display("[TB] FAIL sb_drain: got %0d pending events, expected 0", sb.size());
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
